// File: rtl/alu_rol_seq_pkg.sv
// Shared definitions for the sequential rotate-left unit: FSM states and datapath widths.
package alu_rol_seq_pkg;

  localparam int unsigned ALU_WIDTH    = 32;
  localparam int unsigned ROT_AMT_BITS = 5;

  typedef enum logic [1:0] {
    ROL_IDLE   = 2'd0,
    ROL_ROTATE = 2'd1,
    ROL_DONE   = 2'd2
  } rol_state_t;

endpackage

// File: rtl/alu_rol_seq_step.sv
// Combinational rotate-left of x by k positions; k is at most STEP.
module alu_rol_step
  import alu_rol_seq_pkg::*;
#(
  parameter int unsigned STEP  = 1,
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]         x,
  input  logic [$clog2(STEP):0]    k,
  output logic [WIDTH-1:0]         y
);

  always_comb begin
    if (k == '0) y = x;
    else         y = (x << k) | (x >> (WIDTH - k));
  end

endmodule

// File: rtl/alu_rol_seq.sv
// Multi-cycle rotate-left: rotates A by B[4:0], up to STEP positions per cycle,
// behind a start/busy/done handshake.
module alu_rol_seq
  import alu_rol_seq_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH,
  parameter int unsigned STEP  = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] R,
  output logic             busy,
  output logic             done
);

  localparam int unsigned KW = $clog2(STEP) + 1;
  localparam logic [ROT_AMT_BITS-1:0] STEP_AMT = ROT_AMT_BITS'(STEP);

  rol_state_t              state_q, state_d;
  logic [WIDTH-1:0]        acc_q, acc_d;
  logic [WIDTH-1:0]        r_q, r_d;
  logic [ROT_AMT_BITS-1:0] cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic [ROT_AMT_BITS-1:0] m_amt;
  logic [ROT_AMT_BITS-1:0] k_amt;
  logic [ROT_AMT_BITS-1:0] cnt_rem;
  logic [KW-1:0]           k;
  logic [WIDTH-1:0]        acc_rot;
  logic                    unused_b_hi;

  assign m_amt       = B[ROT_AMT_BITS-1:0];
  assign unused_b_hi = ^B[WIDTH-1:ROT_AMT_BITS];
  assign k_amt       = (cnt_q >= STEP_AMT) ? STEP_AMT : cnt_q;
  assign k           = k_amt[KW-1:0];
  assign cnt_rem     = cnt_q - k_amt;

  alu_rol_step #(
    .STEP  (STEP),
    .WIDTH (WIDTH)
  ) u_step (
    .x (acc_q),
    .k (k),
    .y (acc_rot)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ROL_IDLE: begin
        if (start) begin
          acc_d = A;
          cnt_d = m_amt;
          // A zero rotate completes on the accepting edge, so busy never rises.
          if (m_amt == '0) begin
            r_d     = A;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ROL_DONE;
          end else begin
            busy_d  = 1'b1;
            state_d = ROL_ROTATE;
          end
        end
      end
      ROL_ROTATE: begin
        acc_d = acc_rot;
        cnt_d = cnt_rem;
        if (cnt_rem == '0) begin
          r_d     = acc_rot;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ROL_DONE;
        end
      end
      ROL_DONE: begin
        state_d = ROL_IDLE;
      end
      default: begin
        state_d = ROL_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= ROL_IDLE;
      acc_q   <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign R    = r_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_alu_rol_seq.sv
// Bench for alu_rol_seq: one instance per legal STEP, shared stimulus, rotr-based reference model.
module tb_alu_rol_seq;

  localparam int NI = 5;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [31:0] A, B;
  logic [31:0] r_o   [NI];
  logic        busy_o[NI];
  logic        done_o[NI];

  int compared   = 0;
  int mismatched = 0;
  int lat_a   [NI];
  int pulses_a[NI];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    alu_rol_seq #(.WIDTH(32), .STEP(1 << g)) u_dut (
      .clock (clock),
      .clear (clear),
      .start (start),
      .A     (A),
      .B     (B),
      .R     (r_o[g]),
      .busy  (busy_o[g]),
      .done  (done_o[g])
    );
  end

  function automatic logic [31:0] ref_rol(input logic [31:0] a, input logic [31:0] b);
    int s;
    s = (32 - int'(b % 32)) % 32;
    if (s == 0) return a;
    return (a >> s) | (a << (32 - s));
  endfunction

  function automatic int exp_lat(input int m, input int g);
    int step;
    step = 1 << g;
    return 1 + (m + step - 1) / step;
  endfunction

  // Accept one operation on all instances, then observe 40 edges.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit interfere);
    int m;
    logic [31:0] expr;
    logic exp_busy;
    m = int'(b % 32);
    expr = ref_rol(a, b);
    for (int g = 0; g < NI; g++) begin
      lat_a[g] = 0;
      pulses_a[g] = 0;
    end
    @(negedge clock);
    A = a; B = b; start = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clock);
      for (int g = 0; g < NI; g++) begin
        if (done_o[g] === 1'b1) begin
          pulses_a[g]++;
          lat_a[g] = e;
        end
        exp_busy = (m != 0) && (e < exp_lat(m, g));
        compared++;
        if (busy_o[g] !== exp_busy) begin
          mismatched++;
          $display("FAIL busy step=%0d edge=%0d: got %b expected %b", 1 << g, e, busy_o[g], exp_busy);
        end
      end
      A = $urandom; B = $urandom;
      start = interfere && (e <= 3);
    end
    start = 1'b0;
    for (int g = 0; g < NI; g++) begin
      compared++;
      if (r_o[g] !== expr) begin
        mismatched++;
        $display("FAIL result step=%0d A=%h B=%h: got %h expected %h", 1 << g, a, b, r_o[g], expr);
      end
      compared++;
      if (pulses_a[g] != 1) begin
        mismatched++;
        $display("FAIL done_pulses step=%0d: got %0d expected 1", 1 << g, pulses_a[g]);
      end
      compared++;
      if (lat_a[g] != exp_lat(m, g)) begin
        mismatched++;
        $display("FAIL latency step=%0d M=%0d: got %0d expected %0d", 1 << g, m, lat_a[g], exp_lat(m, g));
      end
    end
  endtask

  task automatic check_cleared(input string tag);
    for (int g = 0; g < NI; g++) begin
      compared++;
      if (r_o[g] !== 32'h0 || busy_o[g] !== 1'b0 || done_o[g] !== 1'b0) begin
        mismatched++;
        $display("FAIL %s step=%0d: got R=%h busy=%b done=%b expected R=0 busy=0 done=0",
                 tag, 1 << g, r_o[g], busy_o[g], done_o[g]);
      end
    end
  endtask

  task automatic test_reset();
    clear = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clock);
    check_cleared("reset");
    clear = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    run_op(32'h8000_0001, 32'd1, 1'b0);
    compared++;
    if (r_o[0] !== 32'h0000_0003 || lat_a[0] != 2) begin
      mismatched++;
      $display("FAIL basic_step1: got R=%h lat=%0d expected R=00000003 lat=2", r_o[0], lat_a[0]);
    end
  endtask

  task automatic test_step4();
    run_op(32'h0000_0001, 32'd31, 1'b0);
    compared++;
    if (r_o[2] !== 32'h8000_0000 || lat_a[2] != 9) begin
      mismatched++;
      $display("FAIL step4_m31: got R=%h lat=%0d expected R=80000000 lat=9", r_o[2], lat_a[2]);
    end
    compared++;
    if (lat_a[0] != 32) begin
      mismatched++;
      $display("FAIL step1_m31 latency: got %0d expected 32", lat_a[0]);
    end
  endtask

  task automatic test_amount_wrap();
    logic [31:0] bv [3];
    logic [31:0] ev [3];
    bv[0] = 32'd0;  ev[0] = 32'h1234_5678;
    bv[1] = 32'd32; ev[1] = 32'h1234_5678;
    bv[2] = 32'd33; ev[2] = 32'h2468_ACF0;
    for (int i = 0; i < 3; i++) begin
      run_op(32'h1234_5678, bv[i], 1'b0);
      compared++;
      if (r_o[0] !== ev[i]) begin
        mismatched++;
        $display("FAIL wrap B=%0d: got %h expected %h", bv[i], r_o[0], ev[i]);
      end
    end
  endtask

  task automatic test_ignore_start();
    run_op(32'hDEAD_BEEF, 32'd20, 1'b1);
  endtask

  task automatic test_clear_mid();
    int pulses;
    @(negedge clock);
    A = $urandom; B = 32'd20; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    clear = 1'b1;
    #1;
    check_cleared("clear_mid");
    @(negedge clock);
    clear = 1'b0;
    pulses = 0;
    for (int e = 0; e < 30; e++) begin
      @(negedge clock);
      for (int g = 0; g < NI; g++) if (done_o[g] === 1'b1) pulses++;
    end
    compared++;
    if (pulses != 0) begin
      mismatched++;
      $display("FAIL clear_no_done: got %0d pulses expected 0", pulses);
    end
    run_op(32'hCAFE_F00D, 32'd7, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, x2;
    int lat;
    x1 = $urandom; x2 = $urandom;
    @(negedge clock);
    A = x1; B = 32'd0; start = 1'b1;
    @(negedge clock);
    compared++;
    if (done_o[0] !== 1'b1 || r_o[0] !== x1) begin
      mismatched++;
      $display("FAIL b2b_first: got done=%b R=%h expected done=1 R=%h", done_o[0], r_o[0], x1);
    end
    start = 1'b0;
    @(negedge clock);
    A = x2; B = 32'd1; start = 1'b1;
    lat = 0;
    for (int e = 1; e <= 10; e++) begin
      @(negedge clock);
      start = 1'b0;
      if (done_o[0] === 1'b1 && lat == 0) lat = e;
    end
    compared++;
    if (lat != 2 || r_o[0] !== ref_rol(x2, 32'd1)) begin
      mismatched++;
      $display("FAIL b2b_second: got lat=%0d R=%h expected lat=2 R=%h", lat, r_o[0], ref_rol(x2, 32'd1));
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_op($urandom, $urandom, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_step4();
    test_amount_wrap();
    test_ignore_start();
    test_clear_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
